// File: rtl/jts16_busarb_pkg.sv
// jts16_busarb_pkg: state encoding shared by the bus-mastership controller.
package jts16_busarb_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] ADDR = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] REL  = 3'd5;

endpackage

// File: rtl/jts16_busarb.sv
// jts16_busarb: borrows the 68000 bus through BR/BG/BGACK for a secondary master
// and runs word accesses on it, with grant/DTACK timeouts and a burst limit.
module jts16_busarb
    import jts16_busarb_pkg::*;
#(
    parameter int TOUT     = 255,
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cen,
    input  logic        ASn,
    input  logic        DTACKn,
    input  logic        BGn,
    output logic        BRn,
    output logic        BGACKn,
    output logic        bus_sel,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_rnw,
    output logic        bus_asn,
    output logic        bus_udsn,
    output logic        bus_ldsn,
    input  logic        mst_req,
    input  logic        mst_rnw,
    input  logic [22:0] mst_addr,
    input  logic [15:0] mst_din,
    input  logic [1:0]  mst_dsn,
    output logic [15:0] mst_dout,
    output logic        mst_ack,
    output logic        mst_err
);

    localparam int BW = $clog2(MAXBURST + 1);

    logic [2:0]    st;
    logic [7:0]    cnt;
    logic [BW-1:0] burst;
    logic [1:0]    dsn;
    logic          err_f;
    logic          tout;

    assign tout = cnt >= 8'(TOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            cnt      <= 8'd0;
            burst    <= '0;
            dsn      <= 2'b11;
            err_f    <= 1'b0;
            BRn      <= 1'b1;
            BGACKn   <= 1'b1;
            bus_sel  <= 1'b0;
            bus_addr <= 23'd0;
            bus_dout <= 16'd0;
            bus_rnw  <= 1'b1;
            bus_asn  <= 1'b1;
            bus_udsn <= 1'b1;
            bus_ldsn <= 1'b1;
            mst_dout <= 16'd0;
            mst_ack  <= 1'b0;
            mst_err  <= 1'b0;
        end else begin
            mst_ack <= 1'b0;
            mst_err <= 1'b0;
            if (cpu_cen) begin
                case (st)
                    IDLE: if (mst_req) begin
                        BRn <= 1'b0;
                        cnt <= 8'd0;
                        st  <= REQ;
                    end
                    REQ: begin
                        // Take the bus only between CPU cycles: strobe and DTACK both idle
                        if (!BGn && ASn && DTACKn) begin
                            BRn     <= 1'b1;
                            BGACKn  <= 1'b0;
                            bus_sel <= 1'b1;
                            st      <= ADDR;
                        end else if (tout) begin
                            BRn     <= 1'b1;
                            mst_ack <= 1'b1;
                            mst_err <= 1'b1;
                            st      <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ADDR: begin
                        bus_addr <= mst_addr;
                        bus_dout <= mst_din;
                        bus_rnw  <= mst_rnw;
                        bus_asn  <= 1'b0;
                        dsn      <= mst_dsn;
                        err_f    <= 1'b0;
                        cnt      <= 8'd0;
                        if (mst_rnw) {bus_udsn, bus_ldsn} <= mst_dsn;
                        st <= WAIT;
                    end
                    WAIT: begin
                        if (!bus_rnw) {bus_udsn, bus_ldsn} <= dsn;
                        if (!DTACKn || tout) begin
                            if (!DTACKn && bus_rnw) mst_dout <= bus_din;
                            err_f    <= DTACKn;
                            mst_ack  <= 1'b1;
                            mst_err  <= DTACKn;
                            bus_asn  <= 1'b1;
                            bus_udsn <= 1'b1;
                            bus_ldsn <= 1'b1;
                            bus_rnw  <= 1'b1;
                            burst    <= burst + BW'(1);
                            st       <= DONE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    // Decided one tick after the ack so the master can withdraw its request
                    DONE: st <= (!err_f && burst < BW'(MAXBURST) && mst_req) ? ADDR : REL;
                    REL: begin
                        BGACKn  <= 1'b1;
                        bus_sel <= 1'b0;
                        burst   <= '0;
                        st      <= IDLE;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jts16_busarb.sv
// tb_jts16_busarb: scoreboard bench with a 68000 bus model (grant, CPU cycles, DTACK).
module tb_jts16_busarb;

    logic        clk, rst, cpu_cen, ASn, DTACKn, BGn;
    logic        BRn, BGACKn, bus_sel, bus_rnw, bus_asn, bus_udsn, bus_ldsn;
    logic [22:0] bus_addr, mst_addr;
    logic [15:0] bus_dout, bus_din, mst_din, mst_dout;
    logic        mst_req, mst_rnw, mst_ack, mst_err;
    logic [1:0]  mst_dsn;

    typedef struct packed {
        logic        rnw;
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  dsn;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          grant_dly = 3, dtack_dly = 2, busy = 0;
    int          br_falls = 0, bg_rises = 0;
    int          viol_sel = 0, viol_brbg = 0, viol_asn = 0, viol_bgas = 0;
    logic [1:0]  dsn0, dsn1;
    logic [22:0] cap_addr;
    logic [15:0] cap_dout, rd_exp = 16'd0;
    logic        cap_rnw;

    jts16_busarb dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .ASn(ASn), .DTACKn(DTACKn), .BGn(BGn),
        .BRn(BRn), .BGACKn(BGACKn), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_rnw(bus_rnw), .bus_asn(bus_asn),
        .bus_udsn(bus_udsn), .bus_ldsn(bus_ldsn), .mst_req(mst_req), .mst_rnw(mst_rnw),
        .mst_addr(mst_addr), .mst_din(mst_din), .mst_dsn(mst_dsn), .mst_dout(mst_dout),
        .mst_ack(mst_ack), .mst_err(mst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cpu_cen is high for one clk out of four
    initial begin
        cpu_cen = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            cpu_cen = 1'b1;
            @(negedge clk);
            cpu_cen = 1'b0;
        end
    end

    // Bus model and protocol monitors, evaluated just after each rising edge
    initial begin
        int   brlow, asn_cnt;
        logic brn_q, bgk_q;
        brlow = 0; asn_cnt = 0; brn_q = 1'b1; bgk_q = 1'b1;
        BGn = 1'b1; ASn = 1'b1; DTACKn = 1'b1; bus_din = 16'hA55A;
        forever begin
            @(posedge clk);
            #1;
            viol_sel  += int'(bus_sel && BGACKn);
            viol_brbg += int'(!BRn && !BGACKn);
            viol_asn  += int'(!bus_asn && !ASn);
            viol_bgas += int'(!BGACKn && !ASn);
            if (!cpu_cen) continue;
            brlow = BRn ? 0 : brlow + 1;
            BGn = !(!BRn && brlow > grant_dly);
            ASn = (busy == 0);
            if (busy > 0) busy--;
            asn_cnt = bus_asn ? 0 : asn_cnt + 1;
            if (!bus_asn) begin
                if (asn_cnt == 1) dsn0 = {bus_udsn, bus_ldsn};
                dsn1 = {bus_udsn, bus_ldsn};
                cap_addr = bus_addr;
                cap_dout = bus_dout;
                cap_rnw = bus_rnw;
            end
            DTACKn = !(!bus_asn && asn_cnt >= dtack_dly);
            bus_din = 16'hA55A ^ bus_addr[15:0];
            if (brn_q && !BRn) br_falls++;
            if (!bgk_q && BGACKn) bg_rises++;
            brn_q = BRn;
            bgk_q = BGACKn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!mst_ack && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_ack"}, 32'(mst_ack), 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_err"}, 32'(mst_err), 32'(e.err));
        if (e.err) begin
            chk({tag, "_strb_rel"}, {bus_asn, bus_udsn, bus_ldsn}, 3'b111);
        end else begin
            chk({tag, "_addr"}, cap_addr, e.addr);
            chk({tag, "_rnw"}, 32'(cap_rnw), 32'(e.rnw));
            chk({tag, "_dsn"}, dsn1, e.dsn);
            chk({tag, "_dsn_first"}, dsn0, e.rnw ? e.dsn : 2'b11);
            if (e.rnw) rd_exp = 16'hA55A ^ e.addr[15:0];
            else chk({tag, "_wdata"}, cap_dout, e.data);
        end
        chk({tag, "_dout"}, mst_dout, rd_exp);
    endtask

    task automatic drive(input logic rnw, input logic [22:0] addr, input logic [15:0] data,
                         input logic [1:0] dsn, input logic err);
        mst_rnw = rnw; mst_addr = addr; mst_din = data; mst_dsn = dsn; mst_req = 1'b1;
        sb.push_back('{rnw, addr, data, dsn, err});
    endtask

    task automatic access(input string tag, input logic rnw, input logic [22:0] addr,
                          input logic [15:0] data, input logic [1:0] dsn, input logic err);
        drive(rnw, addr, data, dsn, err);
        wait_ack(tag);
        mst_req = 1'b0;
        tick_wait(1);
        chk({tag, "_pulse"}, {mst_ack, mst_err}, 2'b00);
    endtask

    task automatic wait_rel(input string tag);
        int n;
        n = 0;
        while (!(BGACKn && !bus_sel && BRn) && n < 200) begin
            tick_wait(1);
            n++;
        end
        chk({tag, "_rel"}, {BRn, BGACKn, bus_sel}, 3'b110);
        tick_wait(8);
    endtask

    initial begin
        int bf, bg, n;
        rst = 1'b1; mst_req = 1'b0; mst_rnw = 1'b1; mst_addr = '0; mst_din = '0; mst_dsn = 2'b11;
        tick_wait(3);
        chk("rst_hs", {BRn, BGACKn, bus_sel}, 3'b110);
        chk("rst_strb", {bus_asn, bus_udsn, bus_ldsn, bus_rnw}, 4'hF);
        chk("rst_data", {bus_addr, bus_dout}, 0);
        chk("rst_mst", {mst_dout, mst_ack, mst_err}, 0);
        rst = 1'b0;
        tick_wait(8);

        access("rd", 1'b1, 23'h100000, 16'h0000, 2'b00, 1'b0);
        wait_rel("rd");

        busy = 5; grant_dly = 0;
        access("cpubusy", 1'b0, 23'h001234, 16'hBEEF, 2'b00, 1'b0);
        wait_rel("cpubusy");
        grant_dly = 3;

        access("bytewr", 1'b0, 23'h000ABC, 16'h1357, 2'b01, 1'b0);
        wait_rel("bytewr");

        bf = br_falls; bg = bg_rises;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 23'h004000 + 23'(i), 16'h1100 * 16'(i + 1), 2'b00, 1'b0);
            wait_ack($sformatf("burst%0d", i));
            tick_wait(1);
            if (i == 5) mst_req = 1'b0;
        end
        wait_rel("burst");
        chk("burst_brn", br_falls - bf, 2);
        chk("burst_rel", bg_rises - bg, 2);

        dtack_dly = 100000;
        access("dtout", 1'b1, 23'h000055, 16'h0000, 2'b00, 1'b1);
        wait_rel("dtout");
        dtack_dly = 2;

        grant_dly = 100000;
        access("gtout", 1'b1, 23'h000066, 16'h0000, 2'b00, 1'b1);
        wait_rel("gtout");
        grant_dly = 3;

        dtack_dly = 100000;
        mst_rnw = 1'b1; mst_addr = 23'h000777; mst_dsn = 2'b00; mst_req = 1'b1;
        n = 0;
        while (bus_asn && n < 200) begin
            tick_wait(1);
            n++;
        end
        chk("rstw_asn", 32'(bus_asn), 0);
        tick_wait(10);
        rst = 1'b1;
        tick_wait(1);
        rst = 1'b0;
        chk("rstw_out", {BRn, BGACKn, bus_asn, bus_sel}, 4'b1110);
        rd_exp = 16'd0;
        dtack_dly = 2;
        sb.push_back('{1'b1, 23'h000777, 16'h0000, 2'b00, 1'b0});
        n = 0;
        while (BRn && n < 50) begin
            tick_wait(1);
            n++;
        end
        chk("rstw_rereq", 32'(BRn), 0);
        wait_ack("rstw");
        mst_req = 1'b0;
        wait_rel("rstw");

        chk("mon_sel_bgack", viol_sel, 0);
        chk("mon_br_bgack", viol_brbg, 0);
        chk("mon_asn_overlap", viol_asn, 0);
        chk("mon_bgack_cpu", viol_bgas, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
